dcp_run_ctrl: RTL and testbench

- Execution controller for the debug unit's CPU clock.
- Sequences `clk_cpu` pulses for single-step (T), run-to-breakpoint (G) and halt requests, and replaces the ad-hoc per-command clock generation.
- Compares `pc_chk` against two breakpoint registers after every pulse and enforces an optional cycle limit.
- Reports a stop cause and the number of pulses issued to the command FSM that drives the UART print path.

---
 rtl/dcp_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dcp_run_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dcp_run_ctrl.sv
// rtl/dcp_run_ctrl.sv - CPU clock execution controller: step, run-to-breakpoint, halt, cycle limit.
// Optional PC history (hist_sel/hist_pc) built only when DCP_PC_HIST_EN is defined.
module dcp_run_ctrl #(
    parameter int PULSE_HI = 1,
    parameter int PULSE_LO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [1:0]  cmd_op,
    input  logic        halt,
    input  logic [1:0]  bp_en,
    input  logic [31:0] bp_1,
    input  logic [31:0] bp_2,
    input  logic [31:0] max_cycles,
    input  logic [31:0] pc_chk,
    output logic        clk_cpu,
    output logic        busy,
    output logic        done,
    output logic [2:0]  stop_cause,
    output logic [31:0] cycle_cnt
`ifdef DCP_PC_HIST_EN
    ,
    input  logic [1:0]  hist_sel,
    output logic [31:0] hist_pc
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [31:0] HI_LAST = 32'(PULSE_HI - 1);
    localparam logic [31:0] LO_LAST = 32'(PULSE_LO - 1);

    state_t      state;
    logic [31:0] ph_cnt;
    logic        op_run;
    logic [1:0]  bp_en_q;
    logic [31:0] bp_1_q;
    logic [31:0] bp_2_q;
    logic [31:0] max_q;
    logic        halt_pend;

    assign cmd_rdy = (state == S_IDLE) && !rst;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ph_cnt     <= 32'd0;
            op_run     <= 1'b0;
            bp_en_q    <= 2'b00;
            bp_1_q     <= 32'd0;
            bp_2_q     <= 32'd0;
            max_q      <= 32'd0;
            halt_pend  <= 1'b0;
            clk_cpu    <= 1'b0;
            done       <= 1'b0;
            stop_cause <= 3'd0;
            cycle_cnt  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_vld) begin
                        case (cmd_op)
                            2'b00, 2'b01: begin
                                op_run     <= cmd_op[0];
                                bp_en_q    <= bp_en;
                                bp_1_q     <= bp_1;
                                bp_2_q     <= bp_2;
                                max_q      <= max_cycles;
                                halt_pend  <= 1'b0;
                                stop_cause <= 3'd0;
                                // count is cleared and the first pulse counted in one step
                                cycle_cnt  <= 32'd1;
                                ph_cnt     <= 32'd0;
                                clk_cpu    <= 1'b1;
                                state      <= S_HIGH;
                            end
                            2'b10: begin
                                stop_cause <= 3'd5;
                                done       <= 1'b1;
                                state      <= S_DONE;
                            end
                            default: begin
                                stop_cause <= 3'd7;
                                done       <= 1'b1;
                                state      <= S_DONE;
                            end
                        endcase
                    end
                end
                S_HIGH: begin
                    if (halt) halt_pend <= 1'b1;
                    if (ph_cnt == HI_LAST) begin
                        ph_cnt  <= 32'd0;
                        clk_cpu <= 1'b0;
                        state   <= S_LOW;
                    end else begin
                        ph_cnt <= ph_cnt + 32'd1;
                    end
                end
                S_LOW: begin
                    if (halt) halt_pend <= 1'b1;
                    if (ph_cnt == LO_LAST) begin
                        ph_cnt <= 32'd0;
                        state  <= S_CHECK;
                    end else begin
                        ph_cnt <= ph_cnt + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (halt) halt_pend <= 1'b1;
                    if (!op_run) begin
                        stop_cause <= 3'd1;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (bp_en_q[0] && (pc_chk == bp_1_q)) begin
                        stop_cause <= 3'd2;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (bp_en_q[1] && (pc_chk == bp_2_q)) begin
                        stop_cause <= 3'd3;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (halt_pend) begin
                        stop_cause <= 3'd5;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if ((max_q != 32'd0) && (cycle_cnt >= max_q)) begin
                        stop_cause <= 3'd4;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
                        ph_cnt  <= 32'd0;
                        clk_cpu <= 1'b1;
                        state   <= S_HIGH;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    halt_pend <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DCP_PC_HIST_EN
    logic [31:0] hist [4];

    // history survives command accepts so the host can inspect the last stop
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= 32'd0;
        end else if (state == S_CHECK) begin
            hist[0] <= pc_chk;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    assign hist_pc = hist[hist_sel];
`endif

endmodule

// File: tb/tb_dcp_run_ctrl.sv
// tb/tb_dcp_run_ctrl.sv - table-driven bench with expected-result queue for dcp_run_ctrl.
module tb_dcp_run_ctrl;

    localparam int PULSE_HI = 1;
    localparam int PULSE_LO = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = 2'b00;
    logic        halt = 1'b0;
    logic [1:0]  bp_en = 2'b00;
    logic [31:0] bp_1 = 32'd0;
    logic [31:0] bp_2 = 32'd0;
    logic [31:0] max_cycles = 32'd0;
    logic [31:0] pc_chk;
    logic        clk_cpu;
    logic        busy;
    logic        done;
    logic [2:0]  stop_cause;
    logic [31:0] cycle_cnt;
`ifdef DCP_PC_HIST_EN
    logic [1:0]  hist_sel = 2'b00;
    logic [31:0] hist_pc;
`endif

    dcp_run_ctrl #(.PULSE_HI(PULSE_HI), .PULSE_LO(PULSE_LO)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .halt(halt), .bp_en(bp_en), .bp_1(bp_1), .bp_2(bp_2), .max_cycles(max_cycles),
        .pc_chk(pc_chk), .clk_cpu(clk_cpu), .busy(busy), .done(done),
        .stop_cause(stop_cause), .cycle_cnt(cycle_cnt)
`ifdef DCP_PC_HIST_EN
        , .hist_sel(hist_sel), .hist_pc(hist_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  bp_en;
        logic [31:0] bp1;
        logic [31:0] bp2;
        logic [31:0] maxc;
        logic [31:0] pc0;
        logic        halt_same;
        logic [2:0]  exp_cause;
        logic [31:0] exp_cnt;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [10];
    vec_t sb [$];

    int n_vec = 0;
    int n_err = 0;

    // CPU model: PC advances by 4 on every clk_cpu rising edge
    int          pulses = 0;
    int          pulse_base = 0;
    logic [31:0] pc0 = 32'd0;
    assign pc_chk = pc0 + 32'((pulses - pulse_base) * 4);

    always @(posedge clk_cpu) pulses <= pulses + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int hi_len = 0;
    always @(negedge clk) begin
        if (rst) hi_len = 0;
        else if (clk_cpu) hi_len++;
        else if (hi_len != 0) begin
            chk("pulse_width", 32'(hi_len), 32'(PULSE_HI));
            hi_len = 0;
        end
    end

    task automatic start_cmd(input vec_t v);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_rdy) chk("cmd_rdy_timeout", 32'(cmd_rdy), 32'd1);
        cmd_op     = v.op;
        bp_en      = v.bp_en;
        bp_1       = v.bp1;
        bp_2       = v.bp2;
        max_cycles = v.maxc;
        pc0        = v.pc0;
        pulse_base = pulses;
        halt       = v.halt_same;
        cmd_vld    = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        halt    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        vec_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            chk({name, "_done_timeout"}, 32'(done), 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({name, "_cause"}, 32'(stop_cause), 32'(e.exp_cause));
            chk({name, "_cnt"}, cycle_cnt, e.exp_cnt);
            chk({name, "_pulses"}, 32'(pulses - pulse_base), 32'(e.exp_pulses));
        end
    endtask

    initial begin
        vec_t v;
        logic [2:0] seq [5];

        vecs[0] = '{2'b00, 2'b00, 32'h0,    32'h0,    32'd0, 32'h3000, 1'b0, 3'd1, 32'd1, 1};
        vecs[1] = '{2'b01, 2'b01, 32'h3010, 32'h0,    32'd0, 32'h3000, 1'b0, 3'd2, 32'd4, 4};
        vecs[2] = '{2'b01, 2'b11, 32'h3008, 32'h3008, 32'd0, 32'h3000, 1'b0, 3'd2, 32'd2, 2};
        vecs[3] = '{2'b01, 2'b10, 32'h3008, 32'h3008, 32'd0, 32'h3000, 1'b0, 3'd3, 32'd2, 2};
        vecs[4] = '{2'b01, 2'b00, 32'h0,    32'h0,    32'd5, 32'h3000, 1'b0, 3'd4, 32'd5, 5};
        vecs[5] = '{2'b01, 2'b01, 32'h3010, 32'h0,    32'd3, 32'h3010, 1'b0, 3'd4, 32'd3, 3};
        vecs[6] = '{2'b11, 2'b00, 32'h0,    32'h0,    32'd0, 32'h3000, 1'b0, 3'd7, 32'd3, 0};
        vecs[7] = '{2'b10, 2'b00, 32'h0,    32'h0,    32'd0, 32'h3000, 1'b0, 3'd5, 32'd3, 0};
        vecs[8] = '{2'b00, 2'b00, 32'h0,    32'h0,    32'd0, 32'h3000, 1'b1, 3'd1, 32'd1, 1};
        vecs[9] = '{2'b01, 2'b10, 32'h0,    32'h3004, 32'd0, 32'h3000, 1'b0, 3'd3, 32'd1, 1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_clk_cpu", 32'(clk_cpu), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cause", 32'(stop_cause), 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);

        // step latency: {clk_cpu, done, cmd_rdy} for cycles T+1..T+5
        seq[0] = 3'b100; seq[1] = 3'b000; seq[2] = 3'b000; seq[3] = 3'b010; seq[4] = 3'b001;
        v = vecs[0];
        start_cmd(v);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("step_lat_T+%0d", k + 1), 32'({clk_cpu, done, cmd_rdy}), 32'(seq[k]));
            if (k == 3) begin
                chk("step_lat_cause", 32'(stop_cause), 32'd1);
                chk("step_lat_cnt", cycle_cnt, 32'd1);
                void'(sb.pop_front());
            end
        end

        for (int i = 0; i < 10; i++) begin
            start_cmd(vecs[i]);
            wait_done($sformatf("vec%0d", i));
        end

        // halt during HIGH: pulse completes, run stops with cause 5
        v = '{2'b01, 2'b00, 32'h0, 32'h0, 32'd0, 32'h3000, 1'b0, 3'd5, 32'd1, 1};
        start_cmd(v);
        chk("halt_in_high_clk", 32'(clk_cpu), 32'd1);
        halt = 1'b1;
        @(posedge clk);
        #1;
        halt = 1'b0;
        wait_done("halt_run");

        // reset during LOW
        v = '{2'b01, 2'b00, 32'h0, 32'h0, 32'd0, 32'h3000, 1'b0, 3'd0, 32'd0, 0};
        start_cmd(v);
        void'(sb.pop_front());
        @(negedge clk);
        @(negedge clk);
        chk("low_phase_clk", 32'({clk_cpu, busy}), 32'b01);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_clk_cpu", 32'(clk_cpu), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_cause", 32'(stop_cause), 32'd0);
        chk("mid_rst_cnt", cycle_cnt, 32'd0);
        chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
